// File: rtl/blake2_ctrl_pkg.sv
// Shared Blake2 engine widths and unloader state encoding.
// Imported by the controller and the digest return path.
package blake2_ctrl_pkg;

   localparam int DIGEST_W = 512;
   localparam int BLOCK_W  = 1024;
   localparam int LEN_W    = 128;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] SEND = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_SEND = SEND,
      ST_DONE = DONE
   } unl_state_t;

endpackage

// File: rtl/digest_unloader_if.sv
// Processor-side word stream: valid/ready with a last marker.
// master drives words, slave accepts them.
interface digest_unloader_if #(
   parameter int W = 32
);

   logic [W-1:0] data_out;
   logic         valid_out;
   logic         ready_in;
   logic         last_out;

   modport master (
      output data_out,
      output valid_out,
      output last_out,
      input  ready_in
   );

   modport slave (
      input  data_out,
      input  valid_out,
      input  last_out,
      output ready_in
   );

endinterface

// File: rtl/digest_unloader_word_mux.sv
// Selects word[idx] MSB-first from the captured digest and
// zeroes the bytes past the configured digest length.
module digest_word_mux
   import blake2_ctrl_pkg::*;
#(
   parameter int W  = 32,
   parameter int DB = 64,
   parameter int CW = 4
) (
   input  logic [DIGEST_W-1:0] cap,
   input  logic [CW-1:0]       idx,
   output logic [W-1:0]        word
);

   localparam logic [DIGEST_W-1:0] MASK =
      ~({DIGEST_W{1'b1}} >> (DB * 8));

   logic [DIGEST_W-1:0] masked;
   logic [DIGEST_W-1:0] shifted;

   // mask trailing bytes, then bring word idx to the top
   always_comb begin
      masked  = cap & MASK;
      shifted = masked << (int'(idx) * W);
      word    = shifted[DIGEST_W-1 -: W];
   end

endmodule

// File: rtl/digest_unloader.sv
// Captures the Blake2 digest on a digest_valid rising edge
// and streams it to the processor as bus-width words.
module digest_unloader
   import blake2_ctrl_pkg::*;
#(
   parameter int proc_bus_width = 32,
   parameter int digest_bytes   = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [DIGEST_W-1:0] digest,
   input  logic                digest_valid,
   input  logic                init,
   digest_unloader_if.master   bus,
   output logic                busy,
   output logic                overrun
);

   localparam int NWORDS =
      (digest_bytes * 8 + proc_bus_width - 1) / proc_bus_width;
   localparam int CW =
      (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

   unl_state_t          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DIGEST_W-1:0] cap_q, cap_d;
   logic                ovr_q, ovr_d;
   logic                dv_q;
   logic                cap_evt;
   logic                sending;
   logic                is_last;
   logic [proc_bus_width-1:0] word;

   assign cap_evt = digest_valid & ~dv_q;
   assign sending = (state_q == ST_SEND);
   assign is_last = (cnt_q == LAST_IDX);

   digest_word_mux #(
      .W  (proc_bus_width),
      .DB (digest_bytes),
      .CW (CW)
   ) u_mux (
      .cap  (cap_q),
      .idx  (cnt_q),
      .word (word)
   );

   // dv_q resets high so a level held across reset is not an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dv_q <= 1'b1;
      else          dv_q <= digest_valid;
   end

   // state, counter, capture register and sticky overrun
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cap_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         ovr_q   <= ovr_d;
      end
   end

   // next-state: init overrides everything, incl. a capture edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      ovr_d   = ovr_q;
      if (init) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         cap_d   = '0;
         ovr_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cap_evt) begin
                  cap_d   = digest;
                  cnt_d   = '0;
                  state_d = ST_SEND;
               end
            end
            ST_SEND: begin
               if (cap_evt) ovr_d = 1'b1;
               if (bus.ready_in) begin
                  if (is_last) state_d = ST_DONE;
                  else         cnt_d   = cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (!digest_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // outputs decoded from registered state only
   always_comb begin
      bus.valid_out = sending;
      bus.last_out  = sending & is_last;
      bus.data_out  = sending ? word : '0;
      busy          = sending;
      overrun       = ovr_q;
   end

endmodule

// File: tb/tb_digest_unloader.sv
// Directed bench: two unloaders (32b/64B and 64b/30B) share
// one engine side; expected words come from the byte ramp.
module tb_digest_unloader;
   import blake2_ctrl_pkg::*;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [DIGEST_W-1:0] digest;
   logic [DIGEST_W-1:0] dig1;
   logic                digest_valid;
   logic                init;
   logic                busy1, ovr1, busy2, ovr2;

   int checks   = 0;
   int failures = 0;

   digest_unloader_if #(.W(32)) b1 ();
   digest_unloader_if #(.W(64)) b2 ();

   digest_unloader #(
      .proc_bus_width (32),
      .digest_bytes   (64)
   ) dut1 (
      .clk          (clk),
      .reset_n      (reset_n),
      .digest       (digest),
      .digest_valid (digest_valid),
      .init         (init),
      .bus          (b1.master),
      .busy         (busy1),
      .overrun      (ovr1)
   );

   digest_unloader #(
      .proc_bus_width (64),
      .digest_bytes   (30)
   ) dut2 (
      .clk          (clk),
      .reset_n      (reset_n),
      .digest       (digest),
      .digest_valid (digest_valid),
      .init         (init),
      .bus          (b2.master),
      .busy         (busy2),
      .overrun      (ovr2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [511:0] got,
                      input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] w32(input int k);
      logic [31:0] w;
      for (int b = 0; b < 4; b++)
         w[31-8*b -: 8] = 8'(4*k + b);
      return w;
   endfunction

   // accept words first..n-1 from dut1; bp gives 1,0,0,1 ready
   task automatic drain(input int first, input int n,
                        input bit bp);
      int   got;
      int   cyc;
      logic r;
      got = first;
      cyc = 0;
      while (got < n && cyc < 200) begin
         r = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
         b1.ready_in = r;
         chk("valid", b1.valid_out, 1'b1);
         chk("word", b1.data_out, w32(got));
         chk("last", b1.last_out, got == 15);
         if (b1.valid_out && r) got++;
         tick();
         cyc++;
      end
      b1.ready_in = 1'b0;
      chk("xfers", got, n);
   endtask

   task automatic edge_dv();
      digest_valid = 1'b0;
      tick();
      digest_valid = 1'b1;
      tick();
   endtask

   logic [63:0] exp2 [4];

   initial begin
      exp2[0] = 64'h0001020304050607;
      exp2[1] = 64'h08090A0B0C0D0E0F;
      exp2[2] = 64'h1011121314151617;
      exp2[3] = 64'h18191A1B1C1D0000;
      for (int i = 0; i < 64; i++)
         dig1[511-8*i -: 8] = 8'(i);
      digest       = dig1;
      reset_n      = 1'b0;
      digest_valid = 1'b0;
      init         = 1'b0;
      b1.ready_in  = 1'b0;
      b2.ready_in  = 1'b1;
      #12;
      chk("rst_valid", b1.valid_out, 1'b0);
      chk("rst_data", b1.data_out, 32'h0);
      chk("rst_busy", busy1, 1'b0);
      chk("rst_ovr", ovr1, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
      tick();

      // 1: basic unload, both widths
      b1.ready_in  = 1'b1;
      digest_valid = 1'b1;
      chk("t1_pre_valid", b1.valid_out, 1'b0);
      tick();
      for (int i = 0; i < 16; i++) begin
         chk("t1_valid", b1.valid_out, 1'b1);
         chk("t1_word", b1.data_out, w32(i));
         chk("t1_last", b1.last_out, i == 15);
         chk("t1_busy", busy1, 1'b1);
         chk("t3_valid", b2.valid_out, i < 4);
         if (i < 4) begin
            chk("t3_word", b2.data_out, exp2[i]);
            chk("t3_last", b2.last_out, i == 3);
         end
         tick();
      end
      chk("t1_end_valid", b1.valid_out, 1'b0);
      chk("t1_end_last", b1.last_out, 1'b0);
      chk("t1_end_busy", busy1, 1'b0);
      tick();
      chk("t1_held_dv", b1.valid_out, 1'b0);
      b1.ready_in = 1'b0;

      // 2: backpressure
      edge_dv();
      drain(0, 16, 1'b1);
      chk("t2_end_valid", b1.valid_out, 1'b0);

      // 4: overrun after 5 words
      edge_dv();
      drain(0, 5, 1'b0);
      digest_valid = 1'b0;
      tick();
      digest_valid = 1'b1;
      digest       = ~dig1;
      tick();
      digest       = dig1;
      chk("t4_ovr", ovr1, 1'b1);
      drain(5, 16, 1'b0);
      chk("t4_ovr_done", ovr1, 1'b1);
      chk("t4_end_valid", b1.valid_out, 1'b0);
      init = 1'b1;
      tick();
      init = 1'b0;
      chk("t4_ovr_clr", ovr1, 1'b0);

      // 5: abort after 3 words, dv held high
      edge_dv();
      drain(0, 3, 1'b0);
      init = 1'b1;
      tick();
      init = 1'b0;
      chk("t5_valid", b1.valid_out, 1'b0);
      chk("t5_last", b1.last_out, 1'b0);
      chk("t5_busy", busy1, 1'b0);
      b1.ready_in = 1'b1;
      tick();
      tick();
      chk("t5_no_retrig", b1.valid_out, 1'b0);
      b1.ready_in = 1'b0;
      edge_dv();
      drain(0, 16, 1'b0);

      // init coincident with capture edge
      digest_valid = 1'b0;
      tick();
      digest_valid = 1'b1;
      init         = 1'b1;
      tick();
      init = 1'b0;
      chk("init_win", b1.valid_out, 1'b0);
      tick();
      chk("init_win2", b1.valid_out, 1'b0);

      // 6: async reset after 7 words with overrun set
      edge_dv();
      drain(0, 7, 1'b0);
      edge_dv();
      chk("t6_ovr", ovr1, 1'b1);
      chk("t6_pre_valid", b1.valid_out, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_valid", b1.valid_out, 1'b0);
      chk("t6_last", b1.last_out, 1'b0);
      chk("t6_busy", busy1, 1'b0);
      chk("t6_ovr0", ovr1, 1'b0);
      chk("t6_data", b1.data_out, 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      tick();
      chk("t6_no_trig", b1.valid_out, 1'b0);
      edge_dv();
      drain(0, 16, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/digest_unloader.md
Name: digest_unloader

Overview:
Return path from the Blake2 hash engine to the processor. It captures the 512-bit digest when the engine raises digest_valid and serialises it onto the processor bus as proc_bus_width-bit words under a valid/ready handshake. It sits beside controller, which drives data into the engine. The result is a complete processor-to-engine-to-processor loop.

Parameters:
proc_bus_width, 32, processor word width; power of two, 8..512.
digest_bytes, 64, Blake2 output length in bytes, 1..64; only the first digest_bytes bytes are sent.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
digest  in  512  engine digest; byte 0 is digest[511:504]
digest_valid  in  1  engine digest valid; level, held high until the next init
init  in  1  engine init pulse (shared with controller); aborts/clears this block
data_out  out  proc_bus_width  digest word to processor
valid_out  out  1  data_out is valid
ready_in  in  1  processor accepts data_out
last_out  out  1  data_out is the final word of the digest
busy  out  1  unloader holds an unsent digest
overrun  out  1  sticky: a new digest arrived while a transfer was in progress

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. On reset every output, the state, the counter and the capture register are 0.
- Word count: NWORDS = ceil(digest_bytes*8 / proc_bus_width).
  - Word k = capture[511 - k*proc_bus_width -: proc_bus_width] (MSB-first order).
  - Bits beyond digest_bytes*8 in the last word are forced to 0.
- Capture event: rising edge of digest_valid. A dv_q register detects digest_valid & !dv_q.
  - A level held high never re-triggers.
- States: IDLE, SEND, DONE.
- IDLE, on a capture event:
  - latch digest into the 512-bit register;
  - word counter = 0; go to SEND.
  - valid_out rises on the cycle after the capture edge (latency 1).
- SEND:
  - valid_out = 1; data_out = word[counter]; last_out = (counter == NWORDS-1); busy = 1.
  - Transfer happens on valid_out & ready_in at a clk edge. After a transfer the counter increments and the next word is presented the following cycle.
  - Back-to-back transfers at one word per cycle are supported.
  - While valid_out=1 and ready_in=0, data_out and last_out are held stable.
  - A transfer with last_out=1 moves to DONE; valid_out and last_out are 0 on the next cycle.
- DONE:
  - busy = 0 and valid_out = 0.
  - Return to IDLE when digest_valid=0 or init=1.
  - A capture event in DONE is impossible (digest_valid is still high), so nothing is lost.
- Capture event while in SEND:
  - The current transfer continues unchanged and the new digest is dropped.
  - overrun is set to 1 and stays set until reset or init.
- init=1 in any state, highest priority:
  - next state IDLE; counter = 0; overrun = 0; valid_out = 0 next cycle.
  - The capture register is cleared to 0.
  - A partial transfer is abandoned with no last_out.
- Simultaneous init and capture edge: init wins; the digest is not captured.
- ready_in while valid_out=0 is ignored.
- Asynchronous reset mid-transfer returns every output to 0 immediately.
- Counter width is $clog2(NWORDS) with a minimum of 1 bit. The counter never wraps past NWORDS-1.

Decomposition:
- Shared package blake2_ctrl_pkg:
  - DIGEST_W=512, BLOCK_W=1024, LEN_W=128 (the engine widths also used by controller);
  - state encoding localparams IDLE=2'b00, SEND=2'b01, DONE=2'b10.
- One natural sub-module, digest_word_mux:
  - combinational selection of word[counter] from the 512-bit register;
  - zero-masking of the trailing bytes beyond digest_bytes.
- FSM, counter, edge detect and the overrun flag stay in the top module.

Test Plan:
1. Basic unload, defaults (32-bit bus, 64 bytes): digest=512'h00010203...3F, digest_valid rises, ready_in=1 constant.
   -> valid_out high from cycle+1 for 16 consecutive cycles; words 32'h00010203 .. 32'h3C3D3E3F; last_out only on word 16; busy low afterwards.
2. Backpressure: ready_in toggling 1,0,0,1,...
   -> data_out and last_out stable whenever valid_out=1 & ready_in=0; exactly 16 transfers; no word skipped or repeated.
3. Short digest, digest_bytes=30, proc_bus_width=64:
   -> NWORDS=4; word 3 = bytes 24..29 followed by 16'h0000; last_out on word 3.
4. Overrun: second digest_valid rising edge after 5 words accepted.
   -> remaining 11 words come from the first digest; overrun=1 stays set until the next init pulse clears it.
5. Abort: init pulse after 3 words accepted, digest_valid held high.
   -> valid_out=0 next cycle, state IDLE, no last_out. A later fresh digest_valid edge unloads all 16 words from word 0.
6. Reset mid-transfer: reset_n low after word 7.
   -> valid_out, last_out, busy, overrun and data_out go to 0 asynchronously. After release, a held-high digest_valid does not trigger until it falls and rises again.
